// File: rtl/npu_result_drainer_if.sv
// npu_result_drainer_if: load handshake (row of accumulators plus requant
// controls) and AXI4-Stream result channel of the drain stage.
//   load_valid / load_ready : row load handshake
//   acc_in                  : packed signed accumulators, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   shift_amt, relu_en      : requantization controls, sampled with the row
//   m_tdata/m_tvalid/m_tready/m_tlast : AXI4-Stream result beats
// Modport master is the drainer (stream source), slave is its environment.
interface npu_result_drainer_if #(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32
);
  logic                             load_valid;
  logic                             load_ready;
  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  acc_in;
  logic [4:0]                       shift_amt;
  logic                             relu_en;
  logic [DATA_WIDTH-1:0]            m_tdata;
  logic                             m_tvalid;
  logic                             m_tready;
  logic                             m_tlast;

  modport master (
    input  load_valid, acc_in, shift_amt, relu_en, m_tready,
    output load_ready, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output load_valid, acc_in, shift_amt, relu_en, m_tready,
    input  load_ready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/npu_result_drainer.sv
// npu_result_drainer: captures one row of signed accumulators, requantizes
// every lane to INT8 (round-half-up shift, optional ReLU, saturation) and
// streams the lanes out lane 0 first with TLAST on the final lane.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load handshake + AXI4-Stream result master (modport master)
//   sat_clr    : synchronous clear of sat_count (wins over an increment)
//   busy       : high while a row is being streamed
//   sat_count  : saturating count of lanes clipped by requantization
module npu_result_drainer #(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  npu_result_drainer_if.master bus,
  input  logic                 sat_clr,
  output logic                 busy,
  output logic [15:0]          sat_count
);

  localparam int unsigned IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int unsigned EXT_W = ACC_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(ARRAY_SIZE + 1);
  localparam int unsigned SAT_W = 16;
  localparam int unsigned SUM_W = SAT_W + 1;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(ARRAY_SIZE - 1);
  localparam logic signed [EXT_W-1:0] Q_MAX    = EXT_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] Q_MIN    = ~Q_MAX;

  typedef enum logic {S_IDLE, S_STREAM} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       idx_nxt;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   busy_q, busy_d;
  logic [SAT_W-1:0]       sat_q, sat_d;
  logic [SUM_W-1:0]       sat_sum;
  logic                   load_en;

  logic [DATA_WIDTH-1:0]  buf_q   [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0]  lane_q8 [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0]  clip_vec;
  logic [CNT_W-1:0]       clip_cnt;

  // Requantize one lane; returns {clipped, int8}. One extra bit of headroom
  // keeps the rounding add from overflowing at the accumulator extremes.
  function automatic logic [DATA_WIDTH:0] requant(input logic [ACC_WIDTH-1:0] acc,
                                                  input logic [4:0]           sh,
                                                  input logic                 relu);
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] r;
    logic                    clip;
    logic [DATA_WIDTH-1:0]   q;
    ext = signed'({acc[ACC_WIDTH-1], acc});
    rnd = (sh == 5'd0) ? '0 : (EXT_W'(1) << (sh - 5'd1));
    r   = (ext + rnd) >>> sh;
    if (relu && r[EXT_W-1]) begin
      r = '0;
    end
    if (r > Q_MAX) begin
      q    = Q_MAX[DATA_WIDTH-1:0];
      clip = 1'b1;
    end else if (r < Q_MIN) begin
      q    = Q_MIN[DATA_WIDTH-1:0];
      clip = 1'b1;
    end else begin
      q    = r[DATA_WIDTH-1:0];
      clip = 1'b0;
    end
    return {clip, q};
  endfunction

  // Per-lane requantization of the row currently presented on acc_in.
  always_comb begin
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      {clip_vec[i], lane_q8[i]} = requant(bus.acc_in[i*ACC_WIDTH +: ACC_WIDTH],
                                          bus.shift_amt, bus.relu_en);
    end
  end

  // Number of clipped lanes in the presented row.
  always_comb begin
    clip_cnt = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      clip_cnt = clip_cnt + CNT_W'(clip_vec[i]);
    end
  end

  assign sat_sum = {1'b0, sat_q} + SUM_W'(clip_cnt);
  assign idx_nxt = idx_q + IDX_W'(1);

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    busy_d   = busy_q;
    sat_d    = sat_q;
    load_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.load_valid && bus.load_ready) begin
          load_en  = 1'b1;
          state_d  = S_STREAM;
          idx_d    = '0;
          tdata_d  = lane_q8[0];
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_STREAM: begin
        // m_tvalid is always high in this state, so m_tready alone marks a beat.
        if (bus.m_tready) begin
          if (idx_q == LAST_IDX) begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
          end else begin
            idx_d   = idx_nxt;
            tdata_d = buf_q[idx_nxt];
            tlast_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (sat_clr) begin
      sat_d = '0;
    end else if (load_en) begin
      sat_d = sat_sum[SAT_W] ? {SAT_W{1'b1}} : sat_sum[SAT_W-1:0];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      sat_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      sat_q    <= sat_d;
    end
  end

  // Row buffer; contents are only meaningful after a load, so no reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        buf_q[i] <= lane_q8[i];
      end
    end
  end

  assign bus.load_ready = (state_q == S_IDLE) & rst_n;
  assign bus.m_tdata    = tdata_q;
  assign bus.m_tvalid   = tvalid_q;
  assign bus.m_tlast    = tlast_q;
  assign busy           = busy_q;
  assign sat_count      = sat_q;

endmodule
